// File: rtl/fifo_wr_arbiter.sv
// Multi-requester write arbiter and occupancy tracker for an attached FIFO.
// Define ARB_FIXED_PRIORITY_EN for fixed priority instead of round-robin.
module fifo_wr_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int NREQ  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         gnt,
  input  logic                    rd_req,
  output logic                    rd_valid,
  output logic [WIDTH-1:0]        rd_data,
  output logic                    fifo_write,
  output logic                    fifo_read,
  output logic [WIDTH-1:0]        fifo_write_data,
  input  logic [WIDTH-1:0]        fifo_read_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty,
  output logic                    ovf_err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = PW + 1;

  logic [PW-1:0] gnt_idx;
  logic          any_req;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

`ifdef ARB_FIXED_PRIORITY_EN
  always_comb begin
    gnt_idx = '0;
    any_req = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt_idx = PW'(i);
        any_req = 1'b1;
      end
    end
  end
`else
  logic [PW-1:0] rr_ptr;

  // Walk offsets from high to low so the smallest offset from rr_ptr wins.
  always_comb begin
    logic [SW-1:0] sum;
    logic [PW-1:0] idx;
    gnt_idx = '0;
    any_req = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      sum = {1'b0, rr_ptr} + SW'(i);
      if (sum >= SW'(NREQ))
        sum = sum - SW'(NREQ);
      idx = sum[PW-1:0];
      if (req[idx]) begin
        gnt_idx = idx;
        any_req = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      rr_ptr <= '0;
    else if (fifo_write)
      rr_ptr <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
  end
`endif

  assign fifo_write = any_req & ~full & ~reset;
  assign fifo_read  = rd_req & ~empty & ~reset;
  assign rd_data    = fifo_read_data;

  always_comb begin
    gnt = '0;
    if (fifo_write)
      gnt[gnt_idx] = 1'b1;
  end

  always_comb begin
    fifo_write_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i])
        fifo_write_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      rd_valid <= 1'b0;
      ovf_err  <= 1'b0;
    end else begin
      rd_valid <= fifo_read;
      if (full && (req != '0))
        ovf_err <= 1'b1;
      case ({fifo_write, fifo_read})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter with a queue-based reference model.
// Covers both arbitration builds via ARB_FIXED_PRIORITY_EN.
module tb_fifo_wr_arbiter;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int NREQ  = 4;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [NREQ-1:0]        req = '0;
  logic [NREQ*WIDTH-1:0]  req_data = '0;
  logic [NREQ-1:0]        gnt;
  logic                   rd_req = 1'b0;
  logic                   rd_valid;
  logic [WIDTH-1:0]       rd_data;
  logic                   fifo_write;
  logic                   fifo_read;
  logic [WIDTH-1:0]       fifo_write_data;
  logic [WIDTH-1:0]       fifo_read_data = '0;
  logic [$clog2(DEPTH):0] count;
  logic                   full;
  logic                   empty;
  logic                   ovf_err;

  int checks = 0;
  int failures = 0;
  bit armed = 1'b0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .req_data(req_data),
    .gnt(gnt),
    .rd_req(rd_req),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .fifo_write(fifo_write),
    .fifo_read(fifo_read),
    .fifo_write_data(fifo_write_data),
    .fifo_read_data(fifo_read_data),
    .count(count),
    .full(full),
    .empty(empty),
    .ovf_err(ovf_err)
  );

  // Stand-in for the attached FIFO, driven purely by the DUT strobes.
  logic [WIDTH-1:0] bq[$];
  always @(posedge clk) begin
    if (reset) begin
      bq.delete();
    end else begin
      if (fifo_read && bq.size() > 0)
        fifo_read_data <= bq.pop_front();
      if (fifo_write)
        bq.push_back(fifo_write_data);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: occupancy is the queue length, data is the queue.
  logic [WIDTH-1:0] mq[$];
  int               m_ptr = 0;
  bit               m_ovf = 1'b0;
  bit               m_rdv = 1'b0;
  logic [WIDTH-1:0] m_rdata = '0;
  int               n, j, e_k;
  logic [NREQ-1:0]  e_gnt;
  logic [WIDTH-1:0] e_wd;
  bit               e_rd;

  always @(negedge clk) begin
    if (armed) begin
      n = mq.size();
      e_gnt = '0;
      e_k = 0;
      if (!reset && n < DEPTH && req != '0) begin
        for (int i = 0; i < NREQ; i++) begin
          j = (m_ptr + i) % NREQ;
          if (e_gnt == '0 && req[j]) begin
            e_gnt[j] = 1'b1;
            e_k = j;
          end
        end
      end
      e_wd = (e_gnt != '0) ? req_data[e_k*WIDTH +: WIDTH] : '0;
      e_rd = !reset && rd_req && n > 0;
      chk("gnt", 32'(gnt), 32'(e_gnt));
      chk("fifo_write", 32'(fifo_write), 32'(e_gnt != '0));
      chk("fifo_write_data", 32'(fifo_write_data), 32'(e_wd));
      chk("fifo_read", 32'(fifo_read), 32'(e_rd));
      chk("count", 32'(count), 32'(n));
      chk("full", 32'(full), 32'(n == DEPTH));
      chk("empty", 32'(empty), 32'(n == 0));
      chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
      chk("rd_valid", 32'(rd_valid), 32'(m_rdv));
      if (m_rdv)
        chk("rd_data", 32'(rd_data), 32'(m_rdata));
      if (reset) begin
        mq.delete();
        m_ptr = 0;
        m_ovf = 1'b0;
        m_rdv = 1'b0;
      end else begin
        if (e_rd)
          m_rdata = mq.pop_front();
        if (e_gnt != '0) begin
          mq.push_back(e_wd);
`ifndef ARB_FIXED_PRIORITY_EN
          m_ptr = (e_k + 1) % NREQ;
`endif
        end
        if (n == DEPTH && req != '0)
          m_ovf = 1'b1;
        m_rdv = e_rd;
      end
    end
  end

  task automatic drive(input logic [NREQ-1:0] r, input logic rr,
                       input logic rs);
    @(posedge clk);
    #1;
    req      = r;
    rd_req   = rr;
    reset    = rs;
    req_data = {$urandom};
  endtask

  task automatic step(input logic [NREQ-1:0] r, input logic rr,
                      input logic rs);
    drive(r, rr, rs);
    @(negedge clk);
  endtask

  initial begin
    @(posedge clk);
    #1 armed = 1'b1;
    step('0, 1'b0, 1'b0);
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_ovf_err", 32'(ovf_err), 0);

    for (int i = 0; i < DEPTH; i++) begin
`ifdef ARB_FIXED_PRIORITY_EN
      step(4'b1010, 1'b0, 1'b0);
      chk("fixed_gnt", 32'(gnt), 32'h2);
`else
      step(4'b1111, 1'b0, 1'b0);
      chk("rr_gnt", 32'(gnt), 32'(1 << (i % 4)));
`endif
    end
    step(4'b1111, 1'b0, 1'b0);
    chk("fill_count", 32'(count), 16);
    chk("fill_full", 32'(full), 1);
    chk("fill_gnt", 32'(gnt), 0);
    step(4'b1111, 1'b0, 1'b0);
    chk("fill_ovf", 32'(ovf_err), 1);

    step(4'b0001, 1'b1, 1'b0);
    chk("full_rw_gnt", 32'(gnt), 0);
    chk("full_rw_read", 32'(fifo_read), 1);
    step(4'b0001, 1'b1, 1'b0);
    chk("full_rw_cnt1", 32'(count), 15);
    chk("full_rw_gnt1", 32'(gnt), 1);
    step(4'b0001, 1'b1, 1'b0);
    chk("full_rw_cnt2", 32'(count), 15);
    repeat (15) step('0, 1'b1, 1'b0);
    step('0, 1'b0, 1'b0);
    chk("drain_count", 32'(count), 0);
    chk("drain_empty", 32'(empty), 1);

    drive(4'b0100, 1'b0, 1'b0);
    req_data[23:16] = 8'hA5;
    @(negedge clk);
    chk("a5_gnt", 32'(gnt), 32'h4);
    chk("a5_wdata", 32'(fifo_write_data), 32'hA5);
    step('0, 1'b1, 1'b0);
    chk("a5_read", 32'(fifo_read), 1);
    step('0, 1'b0, 1'b0);
    chk("a5_rd_valid", 32'(rd_valid), 1);
    chk("a5_rd_data", 32'(rd_data), 32'hA5);
    chk("a5_empty", 32'(empty), 1);

    step(4'b0001, 1'b1, 1'b0);
    chk("empty_rw_gnt", 32'(gnt), 1);
    chk("empty_rw_read", 32'(fifo_read), 0);
    step(4'b0001, 1'b0, 1'b0);
    chk("empty_rw_count", 32'(count), 1);
    chk("empty_rw_rdv", 32'(rd_valid), 0);
    repeat (3) step(4'b0001, 1'b0, 1'b0);
    step(4'b0010, 1'b1, 1'b0);
    chk("mid_rw_cnt0", 32'(count), 5);
    step(4'b0010, 1'b1, 1'b0);
    chk("mid_rw_cnt1", 32'(count), 5);
    repeat (4) step(4'b0001, 1'b0, 1'b0);

    step(4'b1111, 1'b1, 1'b1);
    chk("rst9_count", 32'(count), 9);
    chk("rst9_gnt", 32'(gnt), 0);
    chk("rst9_read", 32'(fifo_read), 0);
    chk("rst9_ovf", 32'(ovf_err), 1);
    step(4'b1111, 1'b1, 1'b1);
    chk("rst_after_count", 32'(count), 0);
    chk("rst_after_rdv", 32'(rd_valid), 0);
    chk("rst_after_ovf", 32'(ovf_err), 0);
    chk("rst_after_gnt", 32'(gnt), 0);

    for (int i = 0; i < 300; i++) begin
      if (i < 150)
        step(4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0, 1'b0);
      else
        step(4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, 1'b0);
    end
    step('0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
